// File: rtl/simplez_tx_fifo_pkg.sv
// Shared constants and types for the Simplez buffered screen transmitter.
// Baud divisors assume a 12 MHz system clock.
package simplez_tx_fifo_pkg;

  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;

  localparam logic [8:0] PANTALLA_STATUS_ADR = 9'd508;
  localparam logic [8:0] PANTALLA_DATA_ADR   = 9'd509;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/simplez_tx_fifo_if.sv
// CPU-facing bundle of the screen transmitter: write strobe, status and serial line.
// wr is a one-cycle strobe with no backpressure; ready is advisory, and a write
// seen while the FIFO is full is dropped and recorded in the sticky ovf flag.
interface simplez_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  import simplez_tx_fifo_pkg::*;

  logic                wr;
  logic [7:0]          data;
  logic                ready;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                busy;
  logic                ovf;
  logic                tx;
  tx_state_e           state;

  modport master (
    output wr, data,
    input  ready, empty, count, busy, ovf, tx, state
  );

  modport slave (
    input  wr, data,
    output ready, empty, count, busy, ovf, tx, state
  );

endinterface

// File: rtl/simplez_tx_fifo_ram.sv
// DEPTH x 8 byte store: synchronous write, combinational read.
module simplez_tx_fifo_ram #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [7:0]            rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simplez_tx_fifo.sv
// Buffered 8N1 transmitter for the Simplez screen port: bytes written by the CPU
// are queued and shifted out LSB first; every output is driven from a flop.
module simplez_tx_fifo
  import simplez_tx_fifo_pkg::*;
#(
  parameter int BAUD       = B115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rstn,
  simplez_tx_fifo_if.slave  bus
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam int                  CW        = $clog2(BAUD);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [CW-1:0]       BAUD_LAST = CW'(BAUD - 1);

  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ready_q, empty_q, ovf_q;
  logic [7:0]            rdata;
  logic                  push, pop;

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         baud_q;
  logic [2:0]            bit_idx_q;
  logic [7:0]            shift_q;
  logic                  bit_end;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  // A write into a full FIFO is lost even if a pop happens on the same edge.
  assign push    = bus.wr && (count_q != FULL_CNT);
  assign pop     = (state_q == ST_IDLE) && !empty_q;
  assign bit_end = (baud_q == BAUD_LAST);

  simplez_tx_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (bus.data),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ready/empty are registered from the next count so they move with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
      empty_q <= (count_d == '0);
      if (bus.wr && !push) ovf_q <= 1'b1;
    end
  end

  // State register; tx/busy flops follow the state by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop)                            state_d = ST_START;
      ST_START: if (bit_end)                        state_d = ST_DATA;
      ST_DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:  if (bit_end)                        state_d = ST_IDLE;
      default:                                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != ST_IDLE);
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Every state exit happens on bit_end (or from IDLE), so the counter is zero on entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if ((state_q == ST_IDLE) || bit_end) baud_q <= '0;
      else                                 baud_q <= baud_q + 1'b1;

      if (state_q == ST_START)                bit_idx_q <= '0;
      else if ((state_q == ST_DATA) && bit_end) bit_idx_q <= bit_idx_q + 1'b1;

      if (pop)                                  shift_q <= rdata;
      else if ((state_q == ST_DATA) && bit_end) shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  assign bus.ready = ready_q;
  assign bus.empty = empty_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.ovf   = ovf_q;
  assign bus.tx    = tx_q;
  assign bus.state = state_q;

endmodule

// File: doc/simplez_tx_fifo.md
Name: simplez_tx_fifo

Overview:
Buffered screen peripheral for Simplez. It sits downstream of the processor's screen data address (509) and consumes the bytes the CPU writes there. Written bytes are queued in a FIFO and serialised as 8N1 frames on the tx line. The CPU sees a status bit that polls "space available" rather than "transmitter idle", so bursts of up to DEPTH characters cost no wait loops.

Parameters:
BAUD, `B115200 (from baudgen.vh), clock cycles per serial bit; minimum legal value is 2.
DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 16 by default.

Ports:
clk  input  1  system clock
rstn  input  1  reset; asynchronous, active-low
wr  input  1  one-cycle write strobe (CPU store to PANTALLA_DATA_ADR)
data  input  8  byte to queue (reg_a[7:0])
ready  output  1  FIFO not full; drives the screen status register bit 0
empty  output  1  FIFO holds no bytes
count  output  DEPTH_LOG2+1  bytes currently queued (excludes the byte being shifted)
busy  output  1  serialiser is in a frame (any state other than IDLE)
ovf  output  1  sticky: a write was dropped because the FIFO was full
tx  output  1  serial line; idle high

Behaviour:
- Reset (rstn=0, asynchronous): tx=1, ready=1, empty=1, count=0, busy=0, ovf=0; read/write pointers=0; FSM=IDLE; baud counter=0.
- Reset asserted mid-frame: tx returns to 1 immediately and FIFO contents are discarded.
- All outputs are registered; tx must never glitch.
- Push: on a clk edge with wr=1 and count<DEPTH, data is written at wptr, then wptr increments and wraps modulo DEPTH.
- Full: wr=1 with count==DEPTH drops the byte, leaves pointers unchanged and sets ovf=1. A pop in the same cycle does not rescue the write.
- Pop: occurs only in IDLE with count>0. The byte at rptr loads the shift register and rptr increments with wrap.
- Simultaneous push and pop: both happen and count is unchanged.
- count, empty and ready all update on the same edge as the push or pop.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If !empty, pop and go to START.
  - START: tx=0 for BAUD cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for BAUD cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for BAUD cycles, then go to IDLE.
- Baud counter: cleared on every state entry. A bit ends when counter==BAUD-1.
- Latency: wr at edge T with the FIFO empty and FSM in IDLE gives empty=0 after T, pop at T+1, and tx falls after T+2.
- Back-to-back frames: each frame is 10*BAUD cycles plus 1 IDLE cycle, so stop-to-start spacing is exactly 1 clk beyond the stop bit.
- Bit order is LSB first. No parity.
- Width rules: count is DEPTH_LOG2+1 bits so that the full condition is representable. Pointers are DEPTH_LOG2 bits and wrap naturally.

Decomposition:
- Shared header baudgen.vh supplies the BAUD constants (`B115200, etc.).
- Peripheral address constants (508/509) belong in a shared simplez_defs.vh.
- One sub-module is natural: fifo_ram, a DEPTH x 8 storage array with synchronous write and combinational read at rptr.
- Pointers, count and the FSM live in the top module.

Test Plan:
- Reset: rstn=0 at any time → tx=1, ready=1, empty=1, count=0, busy=0, ovf=0.
- Single byte, BAUD=4: wr with data=0x41 → tx falls 2 cycles after the write edge. The line then carries bits 0,1,0,0,0,0,0,1,0,1 (start, LSB-first data, stop), 4 cycles each; busy drops after 40 cycles.
- Overflow, BAUD=4: 18 consecutive wr cycles with data=0x00..0x11 (data held in the shift register leaves 16 slots).
  - 0x00 is popped; 0x01..0x10 fill the FIFO, giving count=16, ready=0.
  - 0x11 is dropped and ovf=1.
  - Output order on tx is 0x00..0x10.
- Simultaneous push/pop: with count=3 and FSM returning to IDLE, assert wr in the pop cycle → count stays 3 and byte order is preserved.
- Back-to-back, BAUD=4: queue 0x55 and 0xAA → the second start bit begins exactly 41 cycles after the first start bit.
- Reset mid-frame: assert rstn=0 during DATA bit 3 → tx=1 asynchronously. After release: empty=1 and no residual frame is emitted.
